// File: rtl/xor_arbiter_if.sv
// Requester/result bus of the two-requester XOR arbiter.
// The slave modport is the arbiter side; master is the requester/sink side.
interface xor_arbiter_if #(
    parameter int unsigned LEN_W = 4
);
    localparam int unsigned DATA_W = 32;

    logic              req0_i;
    logic              req1_i;
    logic [LEN_W-1:0]  len0_i;
    logic [LEN_W-1:0]  len1_i;
    logic [DATA_W-1:0] a0_i;
    logic [DATA_W-1:0] b0_i;
    logic [DATA_W-1:0] a1_i;
    logic [DATA_W-1:0] b1_i;
    logic              gnt0_o;
    logic              gnt1_o;
    logic [DATA_W-1:0] res_o;
    logic              res_valid_o;
    logic              res_id_o;
    logic              res_last_o;
    logic              res_ready_i;
    logic              busy_o;

    modport slave (
        input  req0_i, req1_i, len0_i, len1_i, a0_i, b0_i, a1_i, b1_i, res_ready_i,
        output gnt0_o, gnt1_o, res_o, res_valid_o, res_id_o, res_last_o, busy_o
    );

    modport master (
        output req0_i, req1_i, len0_i, len1_i, a0_i, b0_i, a1_i, b1_i, res_ready_i,
        input  gnt0_o, gnt1_o, res_o, res_valid_o, res_id_o, res_last_o, busy_o
    );
endinterface

// File: rtl/xor_arbiter.sv
// Two-requester burst arbiter: grants whole bursts round-robin on contention and
// returns a registered a^b word per consumed operand pair.
module xor_arbiter #(
    parameter int unsigned LEN_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    xor_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               prio_q, prio_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               valid_q, valid_d;
    logic               id_q, id_d;
    logic               last_q, last_d;
    logic               owner_req;
    logic               consume;

    // A word is taken when the owner presents one and the output slot is free or draining.
    always_comb begin
        owner_req = owner_q ? bus.req1_i : bus.req0_i;
        consume   = (state_q == BURST) && owner_req && (!valid_q || bus.res_ready_i) && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            rem_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Arbitration and burst sequencing.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0_i || bus.req1_i) begin
                    owner_d = (bus.req0_i && bus.req1_i) ? prio_q : bus.req1_i;
                    rem_d   = owner_d ? bus.len1_i : bus.len0_i;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (consume) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        prio_d  = ~owner_q;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result slot: a new word replaces the old one in the same cycle it is accepted.
    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        if (consume) begin
            res_d   = owner_q ? (bus.a1_i ^ bus.b1_i) : (bus.a0_i ^ bus.b0_i);
            valid_d = 1'b1;
            id_d    = owner_q;
            last_d  = (rem_q == '0);
        end else if (valid_q && bus.res_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign bus.gnt0_o      = consume && !owner_q;
    assign bus.gnt1_o      = consume && owner_q;
    assign bus.busy_o      = (state_q == BURST) && !rst_i;
    assign bus.res_o       = res_q;
    assign bus.res_valid_o = valid_q;
    assign bus.res_id_o    = id_q;
    assign bus.res_last_o  = last_q;
endmodule
